// File: rtl/flatten_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flatten_pkg
// Purpose  : Shared types and default sizes for the ping-pong flatten buffer.
//            flat_state_e  - write/present controller states
//            flat_sample_t - one signed sample at the default width
// Revision : 1.0 - initial release
// ============================================================================
package flatten_pkg;

   localparam int DATA_W_DEF = 22;
   localparam int DEPTH_DEF  = 225;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,   // read bank empty, filling write bank
      S_FULL  = 2'd1,   // read bank presented, filling write bank
      S_STALL = 2'd2    // both banks full, input stalled
   } flat_state_e;

   typedef logic signed [DATA_W_DEF-1:0] flat_sample_t;

endpackage
`default_nettype wire

// File: rtl/flatten_bank.sv
`default_nettype none
// ============================================================================
// Module   : flatten_bank
// Purpose  : One frame of sample storage. Single write port, every entry
//            visible in parallel. Storage is intentionally not reset.
// Ports    : clk      in  clock, rising edge
//            wr_en    in  write strobe
//            wr_addr  in  entry index (arrival order)
//            wr_data  in  signed sample
//            rd_data  out all DEPTH entries, [0:DEPTH-1]
// Revision : 1.0 - initial release
// ============================================================================
module flatten_bank
   import flatten_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   output logic signed [DATA_W-1:0] rd_data [0:DEPTH-1]
);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         rd_data[wr_addr] <= wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pingpong_flatten_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_flatten_buffer
// Purpose  : Double-buffered flatten stage. Serial signed samples fill one
//            bank while the other bank is presented in parallel to the FC
//            consumer. Input is stalled only while both banks hold frames.
// Ports    : clk               in  clock, rising edge
//            rst               in  asynchronous reset, active low
//            i_data_valid      in  sample valid
//            i_data_in         in  signed sample
//            o_data_ready      out sample accepted on valid && ready
//            i_last            in  frame-end marker (checked only with macro)
//            o_buffer_full     out presented bank holds a complete frame
//            o_flattened_data  out presented bank, [0:DEPTH-1] arrival order
//            i_release         in  consumer finished with presented bank
//            o_frame_cnt       out frames committed since reset (wraps)
//            o_frame_err       out sticky framing error
// Config   : FLATTEN_LAST_CHK_EN - when defined, i_last is checked against
//            the frame length; otherwise i_last is ignored, o_frame_err = 0.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_flatten_buffer
   import flatten_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   parameter int  CNT_W  = 16,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_data_valid,
   input  logic signed [DATA_W-1:0] i_data_in,
   output logic                     o_data_ready,
   input  logic                     i_last,
   output logic                     o_buffer_full,
   output logic signed [DATA_W-1:0] o_flattened_data [0:DEPTH-1],
   input  logic                     i_release,
   output logic [CNT_W-1:0]         o_frame_cnt,
   output logic                     o_frame_err
);

   flat_state_e      state, state_nxt;
   logic             wr_sel;
   logic [PTR_W-1:0] ptr;
   logic [CNT_W-1:0] frame_cnt;
   logic             buffer_full;
   logic             data_ready;

   logic beat, at_end, commit, abort, last_err, release_ok, swap;

   logic signed [DATA_W-1:0] bank0_q [0:DEPTH-1];
   logic signed [DATA_W-1:0] bank1_q [0:DEPTH-1];

   assign beat       = i_data_valid && data_ready;
   assign at_end     = (ptr == PTR_W'(DEPTH - 1));
   assign commit     = beat && at_end;
   // A release only means something while a frame is actually presented.
   assign release_ok = i_release && buffer_full;

`ifdef FLATTEN_LAST_CHK_EN
   // An early i_last drops the partial frame; a missing i_last on the final
   // beat still commits. Either mismatch flags the error.
   assign abort    = beat && i_last && !at_end;
   assign last_err = beat && (i_last != at_end);
`else
   logic unused_last;
   assign unused_last = i_last;
   assign abort       = 1'b0;
   assign last_err    = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Next-state logic. swap flips which bank is written / presented.
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      swap      = 1'b0;
      case (state)
         S_FILL: begin
            if (commit) begin
               state_nxt = S_FULL;
               swap      = 1'b1;
            end
         end
         S_FULL: begin
            if (commit && release_ok) begin
               // New frame replaces the released one without a gap.
               swap = 1'b1;
            end else if (commit) begin
               state_nxt = S_STALL;
            end else if (release_ok) begin
               state_nxt = S_FILL;
            end
         end
         S_STALL: begin
            if (release_ok) begin
               state_nxt = S_FULL;
               swap      = 1'b1;
            end
         end
         default: begin
            state_nxt = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_FILL;
         wr_sel      <= 1'b0;
         ptr         <= '0;
         frame_cnt   <= '0;
         buffer_full <= 1'b0;
         data_ready  <= 1'b1;
      end else begin
         state       <= state_nxt;
         buffer_full <= (state_nxt != S_FILL);
         data_ready  <= (state_nxt != S_STALL);
         if (swap) begin
            wr_sel <= ~wr_sel;
         end
         if (commit || abort || (state == S_STALL && release_ok)) begin
            ptr <= '0;
         end else if (beat) begin
            ptr <= ptr + PTR_W'(1);
         end
         if (commit) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end
   end

`ifdef FLATTEN_LAST_CHK_EN
   logic frame_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_err <= 1'b0;
      end else if (last_err) begin
         frame_err <= 1'b1;
      end
   end

   assign o_frame_err = frame_err;
`else
   logic unused_err;
   assign unused_err  = last_err;
   assign o_frame_err = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Storage: bank 0 is written while wr_sel = 0, bank 1 otherwise.
   // ---------------------------------------------------------------------
   flatten_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_bank0 (
      .clk     (clk),
      .wr_en   (beat && !wr_sel),
      .wr_addr (ptr),
      .wr_data (i_data_in),
      .rd_data (bank0_q)
   );

   flatten_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_bank1 (
      .clk     (clk),
      .wr_en   (beat && wr_sel),
      .wr_addr (ptr),
      .wr_data (i_data_in),
      .rd_data (bank1_q)
   );

   // Presented bank is always the one not being written.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         o_flattened_data[k] = wr_sel ? bank0_q[k] : bank1_q[k];
      end
   end

   assign o_data_ready  = data_ready;
   assign o_buffer_full = buffer_full;
   assign o_frame_cnt   = frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_flatten_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pingpong_flatten_buffer
// Purpose  : Self-checking bench for pingpong_flatten_buffer. Accepted
//            samples are pushed to a scoreboard queue and popped a frame at a
//            time when the DUT presents a frame.
// Config   : FLATTEN_LAST_CHK_EN enables the framing-check scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pingpong_flatten_buffer;
   import flatten_pkg::*;

   localparam int DATA_W = 22;
   localparam int DEPTH  = 225;
   localparam int CNT_W  = 16;

   logic         clk        = 1'b0;
   logic         rst        = 1'b0;
   logic         data_valid = 1'b0;
   logic         last       = 1'b0;
   logic         rel        = 1'b0;
   flat_sample_t data_in    = '0;
   logic         data_ready;
   logic         buffer_full;
   logic         frame_err;
   logic [CNT_W-1:0] frame_cnt;
   flat_sample_t flat [0:DEPTH-1];

   int total        = 0;
   int passed       = 0;
   int stall_cycles = 0;
   int mdl_ptr      = 0;
   flat_sample_t part_q[$];
   flat_sample_t exp_q[$];

   always #5 clk = ~clk;

   pingpong_flatten_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_data_valid     (data_valid),
      .i_data_in        (data_in),
      .o_data_ready     (data_ready),
      .i_last           (last),
      .o_buffer_full    (buffer_full),
      .o_flattened_data (flat),
      .i_release        (rel),
      .o_frame_cnt      (frame_cnt),
      .o_frame_err      (frame_err)
   );

   // Drives one sample from a negedge until it is accepted, then updates the
   // reference model. Returns at the negedge following the accepting edge.
   task automatic send(input flat_sample_t v, input logic lst);
      int guard = 0;
      data_valid = 1'b1;
      data_in    = v;
      last       = lst;
      while (!data_ready && guard < 500) begin
         @(negedge clk);
         guard++;
         stall_cycles++;
      end
      if (!data_ready) begin
         total++;
         $display("FAIL send_timeout: ready=%0b after %0d cycles, required 1", data_ready, guard);
         data_valid = 1'b0;
         last       = 1'b0;
         return;
      end
      @(negedge clk);
      data_valid = 1'b0;
      last       = 1'b0;
      part_q.push_back(v);
      mdl_ptr++;
`ifdef FLATTEN_LAST_CHK_EN
      if (lst && mdl_ptr < DEPTH) begin
         part_q.delete();
         mdl_ptr = 0;
      end
`endif
      if (mdl_ptr == DEPTH) begin
         foreach (part_q[i]) exp_q.push_back(part_q[i]);
         part_q.delete();
         mdl_ptr = 0;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (buffer_full !== 1'b0) $display("FAIL rst_full: got %b want 0", buffer_full); else passed++;
      total++; if (data_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", data_ready); else passed++;
      total++; if (frame_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", frame_cnt); else passed++;
      total++; if (frame_err !== 1'b0) $display("FAIL rst_err: got %b want 0", frame_err); else passed++;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_frame();
      int bad, bi;
      flat_sample_t e, bg, be;
      stall_cycles = 0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k == DEPTH - 1) begin
            total++; if (buffer_full !== 1'b0) $display("FAIL t1_early_full: got %b want 0", buffer_full); else passed++;
         end
         send(flat_sample_t'(k), k == DEPTH - 1);
      end
      total++; if (buffer_full !== 1'b1) $display("FAIL t1_full: got %b want 1", buffer_full); else passed++;
      total++; if (frame_cnt !== 16'd1) $display("FAIL t1_cnt: got %0d want 1", frame_cnt); else passed++;
      total++; if (data_ready !== 1'b1 || stall_cycles != 0) $display("FAIL t1_ready: ready=%b stalls=%0d want 1/0", data_ready, stall_cycles); else passed++;
      total++; if (frame_err !== 1'b0) $display("FAIL t1_err: got %b want 0", frame_err); else passed++;
      bad = 0; bi = 0; bg = '0; be = '0;
      if (exp_q.size() < DEPTH) bad = DEPTH;
      else for (int k = 0; k < DEPTH; k++) begin
         e = exp_q.pop_front();
         if (flat[k] !== e) begin if (bad == 0) begin bi = k; bg = flat[k]; be = e; end bad++; end
      end
      total++; if (bad != 0) $display("FAIL t1_frame: %0d bad, idx %0d got %0d want %0d", bad, bi, bg, be); else passed++;
      rel = 1'b1; @(negedge clk); rel = 1'b0;
      total++; if (buffer_full !== 1'b0) $display("FAIL t1_release: got %b want 0", buffer_full); else passed++;
   endtask

   task automatic test_stall();
      int bad, bi;
      flat_sample_t e, bg, be;
      for (int k = 0; k < DEPTH; k++) send(flat_sample_t'(1000 + k), k == DEPTH - 1);
      bad = 0; bi = 0; bg = '0; be = '0;
      if (exp_q.size() < DEPTH) bad = DEPTH;
      else for (int k = 0; k < DEPTH; k++) begin
         e = exp_q.pop_front();
         if (flat[k] !== e) begin if (bad == 0) begin bi = k; bg = flat[k]; be = e; end bad++; end
      end
      total++; if (bad != 0) $display("FAIL t2_frame_a: %0d bad, idx %0d got %0d want %0d", bad, bi, bg, be); else passed++;
      for (int k = 0; k < DEPTH; k++) send(flat_sample_t'(-3 * (k + 1)), k == DEPTH - 1);
      total++; if (data_ready !== 1'b0) $display("FAIL t2_stall_ready: got %b want 0", data_ready); else passed++;
      total++; if (buffer_full !== 1'b1) $display("FAIL t2_stall_full: got %b want 1", buffer_full); else passed++;
      total++; if (frame_cnt !== 16'd3) $display("FAIL t2_cnt: got %0d want 3", frame_cnt); else passed++;
      total++; if (flat[7] !== flat_sample_t'(1007)) $display("FAIL t2_held: got %0d want 1007", flat[7]); else passed++;
      rel = 1'b1; @(negedge clk); rel = 1'b0;
      total++; if (data_ready !== 1'b1) $display("FAIL t2_resume_ready: got %b want 1", data_ready); else passed++;
      total++; if (buffer_full !== 1'b1) $display("FAIL t2_resume_full: got %b want 1", buffer_full); else passed++;
      bad = 0; bi = 0; bg = '0; be = '0;
      if (exp_q.size() < DEPTH) bad = DEPTH;
      else for (int k = 0; k < DEPTH; k++) begin
         e = exp_q.pop_front();
         if (flat[k] !== e) begin if (bad == 0) begin bi = k; bg = flat[k]; be = e; end bad++; end
      end
      total++; if (bad != 0) $display("FAIL t2_frame_b: %0d bad, idx %0d got %0d want %0d", bad, bi, bg, be); else passed++;
   endtask

   task automatic test_back_to_back();
      int bad, bi;
      flat_sample_t e, bg, be;
      for (int k = 0; k < DEPTH - 1; k++) send(flat_sample_t'(2000 + k), 1'b0);
      rel = 1'b1;
      send(flat_sample_t'(2000 + DEPTH - 1), 1'b1);
      rel = 1'b0;
      total++; if (buffer_full !== 1'b1) $display("FAIL t3_full: got %b want 1", buffer_full); else passed++;
      total++; if (frame_cnt !== 16'd4) $display("FAIL t3_cnt: got %0d want 4", frame_cnt); else passed++;
      total++; if (data_ready !== 1'b1) $display("FAIL t3_ready: got %b want 1", data_ready); else passed++;
      bad = 0; bi = 0; bg = '0; be = '0;
      if (exp_q.size() < DEPTH) bad = DEPTH;
      else for (int k = 0; k < DEPTH; k++) begin
         e = exp_q.pop_front();
         if (flat[k] !== e) begin if (bad == 0) begin bi = k; bg = flat[k]; be = e; end bad++; end
      end
      total++; if (bad != 0) $display("FAIL t3_frame: %0d bad, idx %0d got %0d want %0d", bad, bi, bg, be); else passed++;
      rel = 1'b1; @(negedge clk); rel = 1'b0;
      total++; if (buffer_full !== 1'b0) $display("FAIL t3_release: got %b want 0", buffer_full); else passed++;
   endtask

   task automatic test_extremes();
      int bad, bi;
      flat_sample_t e, bg, be, v;
      for (int k = 0; k < DEPTH; k++) begin
         case (k % 3)
            0:       v = flat_sample_t'(-2097152);
            1:       v = flat_sample_t'(2097151);
            default: v = flat_sample_t'(-k);
         endcase
         send(v, k == DEPTH - 1);
      end
      total++; if (frame_cnt !== 16'd5) $display("FAIL t4_cnt: got %0d want 5", frame_cnt); else passed++;
      total++; if (flat[0] !== 22'sh200000) $display("FAIL t4_min: got %0d want -2097152", flat[0]); else passed++;
      total++; if (flat[223] !== 22'sh1FFFFF) $display("FAIL t4_max: got %0d want 2097151", flat[223]); else passed++;
      bad = 0; bi = 0; bg = '0; be = '0;
      if (exp_q.size() < DEPTH) bad = DEPTH;
      else for (int k = 0; k < DEPTH; k++) begin
         e = exp_q.pop_front();
         if (flat[k] !== e) begin if (bad == 0) begin bi = k; bg = flat[k]; be = e; end bad++; end
      end
      total++; if (bad != 0) $display("FAIL t4_frame: %0d bad, idx %0d got %0d want %0d", bad, bi, bg, be); else passed++;
      rel = 1'b1; @(negedge clk); rel = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int bad, bi;
      flat_sample_t e, bg, be;
      for (int k = 0; k < DEPTH; k++) send(flat_sample_t'(3000 + k), k == DEPTH - 1);
      total++; if (frame_cnt !== 16'd6) $display("FAIL t5_cnt_pre: got %0d want 6", frame_cnt); else passed++;
      bad = 0; bi = 0; bg = '0; be = '0;
      if (exp_q.size() < DEPTH) bad = DEPTH;
      else for (int k = 0; k < DEPTH; k++) begin
         e = exp_q.pop_front();
         if (flat[k] !== e) begin if (bad == 0) begin bi = k; bg = flat[k]; be = e; end bad++; end
      end
      total++; if (bad != 0) $display("FAIL t5_frame_pre: %0d bad, idx %0d got %0d want %0d", bad, bi, bg, be); else passed++;
      for (int k = 0; k < 100; k++) send(flat_sample_t'(4000 + k), 1'b0);
      #2 rst = 1'b0;
      #1;
      total++; if (buffer_full !== 1'b0) $display("FAIL t5_async_full: got %b want 0", buffer_full); else passed++;
      total++; if (data_ready !== 1'b1) $display("FAIL t5_async_ready: got %b want 1", data_ready); else passed++;
      total++; if (frame_cnt !== 16'd0) $display("FAIL t5_async_cnt: got %0d want 0", frame_cnt); else passed++;
      total++; if (frame_err !== 1'b0) $display("FAIL t5_async_err: got %b want 0", frame_err); else passed++;
      part_q.delete(); exp_q.delete(); mdl_ptr = 0;
      @(negedge clk); rst = 1'b1;
      for (int k = 0; k < DEPTH; k++) send(flat_sample_t'(5000 + k), k == DEPTH - 1);
      total++; if (buffer_full !== 1'b1) $display("FAIL t5_full: got %b want 1", buffer_full); else passed++;
      total++; if (frame_cnt !== 16'd1) $display("FAIL t5_cnt: got %0d want 1", frame_cnt); else passed++;
      bad = 0; bi = 0; bg = '0; be = '0;
      if (exp_q.size() < DEPTH) bad = DEPTH;
      else for (int k = 0; k < DEPTH; k++) begin
         e = exp_q.pop_front();
         if (flat[k] !== e) begin if (bad == 0) begin bi = k; bg = flat[k]; be = e; end bad++; end
      end
      total++; if (bad != 0) $display("FAIL t5_frame: %0d bad, idx %0d got %0d want %0d", bad, bi, bg, be); else passed++;
   endtask

`ifdef FLATTEN_LAST_CHK_EN
   task automatic test_last_chk();
      int bad, bi;
      flat_sample_t e, bg, be;
      rel = 1'b1; @(negedge clk); rel = 1'b0;
      for (int k = 0; k < 50; k++) send(flat_sample_t'(6000 + k), k == 49);
      total++; if (buffer_full !== 1'b0) $display("FAIL t6_abort_full: got %b want 0", buffer_full); else passed++;
      total++; if (frame_cnt !== 16'd1) $display("FAIL t6_abort_cnt: got %0d want 1", frame_cnt); else passed++;
      total++; if (frame_err !== 1'b1) $display("FAIL t6_abort_err: got %b want 1", frame_err); else passed++;
      for (int k = 0; k < DEPTH; k++) send(flat_sample_t'(7000 + k), k == DEPTH - 1);
      total++; if (buffer_full !== 1'b1) $display("FAIL t6_full: got %b want 1", buffer_full); else passed++;
      total++; if (frame_cnt !== 16'd2) $display("FAIL t6_cnt: got %0d want 2", frame_cnt); else passed++;
      total++; if (frame_err !== 1'b1) $display("FAIL t6_err_sticky: got %b want 1", frame_err); else passed++;
      bad = 0; bi = 0; bg = '0; be = '0;
      if (exp_q.size() < DEPTH) bad = DEPTH;
      else for (int k = 0; k < DEPTH; k++) begin
         e = exp_q.pop_front();
         if (flat[k] !== e) begin if (bad == 0) begin bi = k; bg = flat[k]; be = e; end bad++; end
      end
      total++; if (bad != 0) $display("FAIL t6_frame: %0d bad, idx %0d got %0d want %0d", bad, bi, bg, be); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_stall();
      test_back_to_back();
      test_extremes();
      test_reset_midframe();
`ifdef FLATTEN_LAST_CHK_EN
      test_last_chk();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
